// File: rtl/mod_multiplier_barrett_pipe.sv
// Four-stage pipelined Barrett modular multiplier: oData = (iData0*iData1) mod iMod.
// Define MOD_MULT_BARRETT_PIPE_OUT_REG_EN to add a fifth output register stage (latency 5).
module mod_multiplier_barrett_pipe #(
    parameter int WIDTH = 32,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iClr,
    input  logic             iValid,
    input  logic [WIDTH-1:0] iData0,
    input  logic [WIDTH-1:0] iData1,
    input  logic [WIDTH-1:0] iMod,
    input  logic [KW-1:0]    iK,
    input  logic [WIDTH:0]   iU,
    output logic             oValid,
    output logic [WIDTH-1:0] oData
);

    // Handshake: operands are taken when iEn=1 and iValid=1; oValid=1 marks a
    // result in oData, and both hold unchanged for as long as iEn=0.

    localparam int ZW = 2 * WIDTH;
    localparam int W1 = WIDTH + 1;
    localparam int MW = 2 * WIDTH + 2;
    localparam int TW = WIDTH + 2;

    // Stage 1
    logic             v1;
    logic [ZW-1:0]    z1;
    logic [WIDTH-1:0] q1;
    logic [KW-1:0]    k1;
    logic [W1-1:0]    u1;

    // Stage 2: only the low TW bits of z are needed, since t is formed mod 2^TW
    logic             v2;
    logic [MW-1:0]    m2;
    logic [TW-1:0]    z2;
    logic [WIDTH-1:0] q2;
    logic [KW-1:0]    k2;

    // Stage 3
    logic             v3;
    logic [TW-1:0]    t3;
    logic [WIDTH-1:0] q3;

    // Stage 4
    logic             v4;
    logic [WIDTH-1:0] d4;

    logic [ZW-1:0]    z_n;
    logic [W1-1:0]    zs_n;
    logic [MW-1:0]    m2_n;
    logic [W1-1:0]    qh_n;
    logic [TW-1:0]    t_n;
    logic [TW-1:0]    q_x1;
    logic [TW-1:0]    q_x2;
    logic [WIDTH-1:0] r_n;

    always_comb begin
        z_n  = ZW'(iData0) * ZW'(iData1);
        zs_n = W1'(z1 >> k1);
        m2_n = MW'(zs_n) * MW'(u1);
        qh_n = W1'(m2 >> k2);
        t_n  = z2 - (TW'(qh_n) * TW'(q2));
        q_x1 = TW'(q3);
        q_x2 = TW'({q3, 1'b0});
        // Barrett with u = floor(4^k/q) leaves t < 3q, so two corrections suffice
        if (t3 >= q_x2) begin
            r_n = WIDTH'(t3 - q_x2);
        end else if (t3 >= q_x1) begin
            r_n = WIDTH'(t3 - q_x1);
        end else begin
            r_n = WIDTH'(t3);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v1 <= 1'b0;
        end else if (iClr) begin
            v1 <= 1'b0;
        end else if (iEn) begin
            v1 <= iValid;
            if (iValid) begin
                z1 <= z_n;
                q1 <= iMod;
                k1 <= iK;
                u1 <= iU;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v2 <= 1'b0;
        end else if (iClr) begin
            v2 <= 1'b0;
        end else if (iEn) begin
            v2 <= v1;
            if (v1) begin
                m2 <= m2_n;
                z2 <= TW'(z1);
                q2 <= q1;
                k2 <= k1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v3 <= 1'b0;
        end else if (iClr) begin
            v3 <= 1'b0;
        end else if (iEn) begin
            v3 <= v2;
            if (v2) begin
                t3 <= t_n;
                q3 <= q2;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v4 <= 1'b0;
            d4 <= '0;
        end else if (iClr) begin
            v4 <= 1'b0;
            d4 <= '0;
        end else if (iEn) begin
            v4 <= v3;
            if (v3) begin
                d4 <= r_n;
            end
        end
    end

`ifdef MOD_MULT_BARRETT_PIPE_OUT_REG_EN
    logic             v5;
    logic [WIDTH-1:0] d5;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v5 <= 1'b0;
            d5 <= '0;
        end else if (iClr) begin
            v5 <= 1'b0;
            d5 <= '0;
        end else if (iEn) begin
            v5 <= v4;
            if (v4) begin
                d5 <= d4;
            end
        end
    end

    assign oValid = v5;
    assign oData  = d5;
`else
    assign oValid = v4;
    assign oData  = d4;
`endif

endmodule

// File: tb/tb_mod_multiplier_barrett_pipe.sv
// Directed bench for mod_multiplier_barrett_pipe: driver tasks push expected results
// and due cycles; a monitor pops and compares whenever a fresh result appears.
module tb_mod_multiplier_barrett_pipe;

    localparam int W  = 32;
    localparam int KW = $clog2(W) + 1;
`ifdef MOD_MULT_BARRETT_PIPE_OUT_REG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic          iClk;
    logic          iRst;
    logic          iEn;
    logic          iClr;
    logic          iValid;
    logic [W-1:0]  iData0;
    logic [W-1:0]  iData1;
    logic [W-1:0]  iMod;
    logic [KW-1:0] iK;
    logic [W:0]    iU;
    logic          oValid;
    logic [W-1:0]  oData;

    mod_multiplier_barrett_pipe #(.WIDTH(W), .KW(KW)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iClr   (iClr),
        .iValid (iValid),
        .iData0 (iData0),
        .iData1 (iData1),
        .iMod   (iMod),
        .iK     (iK),
        .iU     (iU),
        .oValid (oValid),
        .oData  (oData)
    );

    // Clock and watchdog
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           en_cnt  = 0;
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0h req=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver tasks (inputs change on the falling edge)
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [KW-1:0] k, input logic [W:0] u, input logic [W-1:0] e);
        iValid = 1'b1;
        iData0 = a;
        iData1 = b;
        iMod   = q;
        iK     = k;
        iU     = u;
        if (iEn && !iRst && !iClr) begin
            exp_q.push_back(e);
            due_q.push_back(en_cnt + LAT);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [KW-1:0] k, input logic [W:0] u, input logic [W-1:0] e);
        @(negedge iClk);
        drive(a, b, q, k, u, e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iClk);
            iValid = 1'b0;
        end
    endtask

    task automatic gap();
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    endtask

    task automatic flush_exp();
        exp_q.delete();
        due_q.delete();
    endtask

    // Monitor: a fresh result can only appear after an enabled, non-reset, non-clear edge
    initial begin
        logic e, r, c;
        logic [W-1:0] ed;
        int           dd;
        forever begin
            @(posedge iClk);
            e = iEn;
            r = iRst;
            c = iClr;
            #1;
            if (!r && !c && e) begin
                en_cnt++;
                if (oValid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'(oValid), 64'd0);
                    end else begin
                        ed = exp_q.pop_front();
                        dd = due_q.pop_front();
                        check("result_data", 64'(oData), 64'(ed));
                        check("result_latency", 64'(en_cnt), 64'(dd));
                    end
                end else if (exp_q.size() > 0 && due_q[0] <= en_cnt) begin
                    dd = due_q.pop_front();
                    ed = exp_q.pop_front();
                    check("missing_valid", 64'(oValid), 64'd1);
                end
            end
        end
    end

    localparam logic [W-1:0] Q32 = 32'hFFFF_FFFB;
    localparam logic [W:0]   U32 = 33'h1_0000_0005;

    initial begin
        iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iValid = 1'b0;
        iData0 = '0; iData1 = '0; iMod = '0; iK = '0; iU = '0;
        repeat (3) @(negedge iClk);
        check("reset_valid", 64'(oValid), 64'd0);
        check("reset_data", 64'(oData), 64'd0);
        iRst = 1'b0;

        // Large modulus, (q-1)^2 mod q = 1, first op right after reset
        issue(32'hFFFF_FFFA, 32'hFFFF_FFFA, Q32, 6'd32, U32, 32'd1);
        idle(LAT + 2);

        // Back-to-back with changing moduli
        issue(32'd13, 32'd11, 32'd17, 6'd5, 33'd60, 32'd7);
        issue(32'd2, 32'd3, Q32, 6'd32, U32, 32'd6);
        issue(32'd16, 32'd16, 32'd17, 6'd5, 33'd60, 32'd1);
        idle(LAT + 2);

        // Assorted moduli, including the k=2 boundary and a top-bit-set q
        issue(32'd12, 32'd12, 32'd13, 6'd4, 33'd19, 32'd1);            gap();
        issue(32'd7, 32'd5, 32'd13, 6'd4, 33'd19, 32'd9);              gap();
        issue(32'd2, 32'd2, 32'd3, 6'd2, 33'd5, 32'd1);                gap();
        issue(32'd1, 32'd1, 32'd2, 6'd2, 33'd8, 32'd1);                gap();
        issue(32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 6'd32, 33'h1_FFFF_FFFC, 32'd1); gap();
        issue(32'hFFFF_FFFA, 32'd2, Q32, 6'd32, U32, 32'hFFFF_FFF9);   gap();
        issue(32'd0, 32'd9, 32'd17, 6'd5, 33'd60, 32'd0);              gap();
        issue(32'd250, 32'd250, 32'd251, 6'd8, 33'd261, 32'd1);        gap();
        issue(32'd100, 32'd200, 32'd251, 6'd8, 33'd261, 32'd171);
        idle(LAT + 3);
        check("idle_valid", 64'(oValid), 64'd0);
        check("idle_data_hold", 64'(oData), 64'd171);

        // Stall for 3 cycles starting one cycle after accept
        issue(32'd5, 32'd7, 32'd17, 6'd5, 33'd60, 32'd1);
        @(negedge iClk);
        iValid = 1'b0;
        iEn = 1'b0;
        repeat (3) @(negedge iClk);
        iEn = 1'b1;
        idle(LAT + 2);

        // Stall while a result is presented: it must be held, not repeated
        issue(32'd9, 32'd9, 32'd17, 6'd5, 33'd60, 32'd13);
        idle(LAT);
        iEn = 1'b0;
        repeat (2) begin
            @(negedge iClk);
            check("stall_hold_valid", 64'(oValid), 64'd1);
            check("stall_hold_data", 64'(oData), 64'd13);
        end
        iEn = 1'b1;
        idle(LAT + 1);

        // Clear with two ops in flight plus one presented on the clear cycle
        issue(32'd3, 32'd4, 32'd17, 6'd5, 33'd60, 32'd12);
        issue(32'd6, 32'd6, 32'd17, 6'd5, 33'd60, 32'd2);
        @(negedge iClk);
        flush_exp();
        iClr = 1'b1;
        drive(32'd8, 32'd8, 32'd17, 6'd5, 33'd60, 32'd13);
        @(negedge iClk);
        iClr = 1'b0;
        check("clear_valid", 64'(oValid), 64'd0);
        check("clear_data", 64'(oData), 64'd0);
        drive(32'd10, 32'd10, 32'd17, 6'd5, 33'd60, 32'd15);
        idle(LAT + 3);

        // Reset two cycles after an accepted op
        issue(32'd4, 32'd4, 32'd17, 6'd5, 33'd60, 32'd16);
        idle(1);
        @(negedge iClk);
        flush_exp();
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        check("midreset_valid", 64'(oValid), 64'd0);
        check("midreset_data", 64'(oData), 64'd0);
        idle(LAT + 3);
        issue(32'hFFFF_FFFA, 32'hFFFF_FFFA, Q32, 6'd32, U32, 32'd1);
        idle(LAT + 2);

        // Bounded drain
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge iClk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_multiplier_barrett_pipe.md
MOD_MULTIPLIER_BARRETT_PIPE -- requirements
Module: mod_multiplier_barrett_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and modulus width in bits; legal range 4..64.
REQ-002 Parameter KW, default $clog2(WIDTH)+1: width of the iK port.
REQ-003 iClk  input  1  sole clock; all state updates on its rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iEn  input  1  pipeline advance enable; low freezes every stage.
REQ-006 iClr  input  1  synchronous flush of all stages.
REQ-007 iValid  input  1  marks the current operand set as a live operation.
REQ-008 iData0, iData1  input  WIDTH each  multiplicands a, b; each < iMod.
REQ-009 iMod  input  WIDTH  modulus q, with 2^(iK-1) <= q < 2^iK.
REQ-010 iK  input  KW  bit length of q; range 2..WIDTH.
REQ-011 iU  input  WIDTH+1  precomputed floor(4^iK / q).
REQ-012 oValid  output  1  oData holds a completed result.
REQ-013 oData  output  WIDTH  (a*b) mod q.

Function
REQ-014 Fully pipelined; one operation accepted per cycle while iEn=1; iMod, iK and iU are sampled with each operation and carried down the pipe, so consecutive operations may use different moduli.
REQ-015 S1 registers z=a*b (2*WIDTH bits) plus q, k, u and valid.
REQ-016 S2 registers m2=(z>>k)*u, with z>>k held in WIDTH+1 bits and m2 in 2*WIDTH+2 bits, plus z, q, k and valid.
REQ-017 S3 registers t=(z-((m2>>k)*q)) mod 2^(WIDTH+2), with m2>>k held in WIDTH+1 bits, plus q and valid.
REQ-018 S4 registers oData: t-2q if t>=2q, else t-q if t>=q, else t; oValid <= S3 valid.
REQ-019 Latency is 4 iEn-high cycles from the sampling edge to oValid=1, with exactly one oValid pulse per accepted iValid.
REQ-020 iEn=0 holds all data and valid registers, including oData/oValid, with no loss or duplication.
REQ-021 iClr=1 zeroes all valid bits and oData next edge regardless of iEn; the operation presented that cycle is discarded.
REQ-022 Precedence: iRst > iClr > iEn.
REQ-023 Stage data registers load only when iEn=1 and that stage's incoming valid=1; bubbles do not disturb oData, and oData holds its last result while oValid=0.
REQ-024 Out-of-range inputs (a>=q, bad u/k) produce an unspecified oData but correct oValid timing.

Reset
REQ-025 iRst=1 at a clock edge sets oData=0, oValid=0 and all internal valid bits to 0, even mid-operation; in-flight operations are lost.
REQ-026 The first iValid sampled on the edge after iRst deasserts yields oValid 4 cycles later.

Configuration
REQ-027 Macro MOD_MULT_BARRETT_PIPE_OUT_REG_EN adds a fifth register stage after S4, giving latency 5, oData/oValid taken from that stage and stage 5 obeying REQ-020..REQ-025.
REQ-028 Without the macro, latency is 4 and oData/oValid come directly from S4.

Verification
REQ-029 WIDTH=32, q=0xFFFFFFFB, k=32, u=0x100000005, a=b=0xFFFFFFFA, iValid pulse -> oValid=1 exactly 4 cycles later with oData=1.
REQ-030 Back-to-back ops (q=17,k=5,u=60,a=13,b=11), then (q=0xFFFFFFFB,k=32,u=0x100000005,a=2,b=3), then (q=17,k=5,u=60,a=16,b=16) -> oValid on 3 consecutive cycles with oData=7, 6, 1.
REQ-031 Op (q=17,k=5,u=60,a=5,b=7), iEn low for 3 cycles starting 1 cycle after accept -> oValid after 4 iEn-high cycles (7 cycles total) with oData=1, appearing once.
REQ-032 Two ops in flight, iClr pulsed -> neither produces oValid; an op issued the next cycle returns normally after 4 cycles.
REQ-033 iRst asserted 2 cycles after an accepted op -> oData=0, oValid=0, with no stale result afterwards; rerun the REQ-029 vector -> oData=1.
REQ-034 Random regression against a golden (a*b)%q for WIDTH 8, 32 and 64, with and without the macro -> zero mismatches over 1e5 ops, with random iEn/iValid gaps.
